// File: rtl/line_pos_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_pos_ctrl_if
//  Description : Control/status bundle for one on-screen line or edge position.
//                The master drives the move/load controls; the slave returns
//                the position and its bound/bounce flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface line_pos_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             tick;
  logic             up;
  logic             dw;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             mode;
  logic [WIDTH-1:0] pos;
  logic             dir;
  logic             at_max;
  logic             at_min;
  logic             bounce;

  modport master (
    output tick, up, dw, ld, ld_val, mode,
    input  pos, dir, at_max, at_min, bounce
  );

  modport slave (
    input  tick, up, dw, ld, ld_val, mode,
    output pos, dir, at_max, at_min, bounce
  );
endinterface
`default_nettype wire

// File: rtl/line_pos_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_pos_ctrl
//  Description : Position register for one line/edge of the on-screen cube.
//                Steps between MIN_POS and MAX_POS once per tick, either under
//                up/dw button control (MANUAL) or autonomously (BOUNCE).
//                Loadable from switches; clamps at both bounds.
//  Revision    : 1.0  initial release
// ============================================================================
module line_pos_ctrl #(
  parameter int WIDTH     = 16,
  parameter int MIN_POS   = 18,
  parameter int MAX_POS   = 487,
  parameter int STEP      = 1,
  parameter int RESET_POS = 18
) (
  input  wire             clk,
  input  wire             reset,
  line_pos_ctrl_if.slave  bus
);

  // Bounds as WIDTH-bit constants; MIN_POS+STEP never exceeds MAX_POS so it fits.
  localparam logic [WIDTH-1:0] C_MIN       = WIDTH'(MIN_POS);
  localparam logic [WIDTH-1:0] C_MAX       = WIDTH'(MAX_POS);
  localparam logic [WIDTH-1:0] C_STEP      = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] C_RESET     = WIDTH'(RESET_POS);
  localparam logic [WIDTH-1:0] C_DEC_FLOOR = WIDTH'(MIN_POS + STEP);

  // Reject illegal parameter sets at elaboration time.
  if (MIN_POS < 0 || MIN_POS > RESET_POS || RESET_POS > MAX_POS) begin : g_bad_reset_pos
    $error("line_pos_ctrl: need MIN_POS <= RESET_POS <= MAX_POS");
  end
  if (WIDTH < 1 || WIDTH > 31 || longint'(MAX_POS) >= (longint'(1) << WIDTH)) begin : g_bad_width
    $error("line_pos_ctrl: MAX_POS must fit in WIDTH bits (WIDTH 1..31)");
  end
  if (STEP < 1 || STEP > (MAX_POS - MIN_POS)) begin : g_bad_step
    $error("line_pos_ctrl: need 1 <= STEP <= MAX_POS-MIN_POS");
  end
  if ($bits(bus.pos) != WIDTH) begin : g_bad_bus_width
    $error("line_pos_ctrl: interface WIDTH does not match module WIDTH");
  end

  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             bounce_q, bounce_d;

  // Increment is formed one bit wider so it cannot wrap before the bound test.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_inc_hits_max;
  logic             w_dec_hits_min;
  logic [WIDTH-1:0] w_inc_sat;
  logic [WIDTH-1:0] w_dec_sat;
  logic [WIDTH-1:0] w_ld_clamped;

  assign w_sum          = {1'b0, pos_q} + {1'b0, C_STEP};
  // Only used when pos_q > MIN_POS+STEP, so the subtraction never underflows.
  assign w_diff         = pos_q - C_STEP;
  assign w_inc_hits_max = (w_sum >= {1'b0, C_MAX});
  // pos-STEP <= MIN  <=>  pos <= MIN+STEP, avoiding a negative intermediate.
  assign w_dec_hits_min = (pos_q <= C_DEC_FLOOR);
  assign w_inc_sat      = w_inc_hits_max ? C_MAX : w_sum[WIDTH-1:0];
  assign w_dec_sat      = w_dec_hits_min ? C_MIN : w_diff;
  assign w_ld_clamped   = (bus.ld_val < C_MIN) ? C_MIN :
                          (bus.ld_val > C_MAX) ? C_MAX : bus.ld_val;

  // Next-state selection: load beats tick-move, which beats hold.
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    if (bus.ld) begin
      pos_d = w_ld_clamped;
    end else if (bus.tick) begin
      if (!bus.mode) begin
        if (bus.up && !bus.dw) begin
          pos_d = w_inc_sat;
          dir_d = 1'b0;
        end else if (bus.dw && !bus.up) begin
          pos_d = w_dec_sat;
          dir_d = 1'b1;
        end
      end else if (!dir_q) begin
        if (w_inc_hits_max) begin
          pos_d    = C_MAX;
          dir_d    = 1'b1;
          bounce_d = 1'b1;
        end else begin
          pos_d = w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_dec_hits_min) begin
          pos_d    = C_MIN;
          dir_d    = 1'b0;
          bounce_d = 1'b1;
        end else begin
          pos_d = w_diff;
        end
      end
    end
  end

  // State registers with immediate (asynchronous) reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q    <= C_RESET;
      dir_q    <= 1'b0;
      bounce_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
    end
  end

  assign bus.pos    = pos_q;
  assign bus.dir    = dir_q;
  assign bus.bounce = bounce_q;
  assign bus.at_max = (pos_q == C_MAX);
  assign bus.at_min = (pos_q == C_MIN);

endmodule
`default_nettype wire
